// File: rtl/cam_cfg_pkg.sv
// cam_cfg_pkg: shared states, table codes and OV7670 register addresses
package cam_cfg_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DECODE,
        REQ,
        DELAY,
        DONE,
        ERROR
    } state_t;

    localparam logic [15:0] TBL_END   = 16'hFFFF;
    localparam logic [15:0] TBL_DELAY = 16'hFFF0;

    localparam logic [7:0] CLKRC      = 8'h11;
    localparam logic [7:0] COM7       = 8'h12;
    localparam logic [7:0] COM10      = 8'h15;
    localparam logic [7:0] TSLB       = 8'h3A;
    localparam logic [7:0] COM15      = 8'h40;
    localparam logic [7:0] COM7_RESET = 8'h80;

endpackage

// File: rtl/sccb_config_sequencer.sv
// sccb_config_sequencer: walks a register-init table and issues SCCB writes with delay markers and retries
module sccb_config_sequencer
    import cam_cfg_pkg::*;
#(
    parameter logic [7:0] DEV_ADDR    = 8'h42,
    parameter int         TBL_AW      = 7,
    parameter int         DELAY_CYC   = 1_000_000,
    parameter int         ACK_TIMEOUT = 65_535,
    parameter int         MAX_RETRY   = 3,
    parameter bit         AUTO_START  = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic [TBL_AW-1:0] tbl_addr,
    input  logic [15:0]       tbl_data,
    output logic              sccb_req,
    output logic [7:0]        sccb_dev_addr,
    output logic [7:0]        sccb_reg_addr,
    output logic [7:0]        sccb_wdata,
    input  logic              sccb_ack,
    input  logic              sccb_nack,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [TBL_AW-1:0] err_index
);

    localparam int TMAX = (DELAY_CYC > ACK_TIMEOUT) ? DELAY_CYC : ACK_TIMEOUT;
    localparam int TW   = $clog2(TMAX + 1);
    localparam int RW   = $clog2(MAX_RETRY + 1);
    localparam logic [TBL_AW-1:0] LAST = '1;

    state_t            state_q, state_d;
    logic [TBL_AW-1:0] idx_q, idx_d, tbl_addr_q, tbl_addr_d, err_idx_q, err_idx_d;
    logic [TW-1:0]     tmr_q, tmr_d;
    logic [RW-1:0]     rty_q, rty_d;
    logic [7:0]        reg_q, reg_d, wdata_q, wdata_d;
    logic              ph_q, ph_d, gap_q, gap_d, arm_q, arm_d;
    logic              req_q, req_d, busy_q, busy_d, done_q, done_d, error_q, error_d;
    logic              last, fail;

    assign last          = idx_q == LAST;
    assign fail          = sccb_nack || tmr_q == TW'(ACK_TIMEOUT);
    assign tbl_addr      = tbl_addr_q;
    assign sccb_req      = req_q;
    assign sccb_dev_addr = DEV_ADDR;
    assign sccb_reg_addr = reg_q;
    assign sccb_wdata    = wdata_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign error         = error_q;
    assign err_index     = err_idx_q;

    // Next-state logic: FETCH spends two cycles so the registered address reaches the 1-cycle ROM before DECODE
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        tbl_addr_d = tbl_addr_q;
        err_idx_d  = err_idx_q;
        tmr_d      = tmr_q;
        rty_d      = rty_q;
        reg_d      = reg_q;
        wdata_d    = wdata_q;
        ph_d       = ph_q;
        gap_d      = gap_q;
        arm_d      = 1'b0;
        req_d      = req_q;
        busy_d     = busy_q;
        done_d     = done_q;
        error_d    = error_q;
        case (state_q)
            IDLE, DONE, ERROR: begin
                if (start || arm_q) begin
                    state_d = FETCH;
                    idx_d   = '0;
                    ph_d    = 1'b0;
                    done_d  = 1'b0;
                    error_d = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            FETCH: begin
                tbl_addr_d = idx_q;
                ph_d       = !ph_q;
                state_d    = ph_q ? DECODE : FETCH;
            end
            DECODE: begin
                if (tbl_data == TBL_END) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end else if (tbl_data == TBL_DELAY) begin
                    state_d = DELAY;
                    tmr_d   = TW'(DELAY_CYC - 1);
                end else begin
                    state_d = REQ;
                    reg_d   = tbl_data[15:8];
                    wdata_d = tbl_data[7:0];
                    rty_d   = '0;
                    tmr_d   = '0;
                    gap_d   = 1'b0;
                    req_d   = 1'b1;
                end
            end
            REQ: begin
                if (gap_q) begin
                    gap_d = 1'b0;
                    req_d = 1'b1;
                    tmr_d = '0;
                end else if (fail) begin
                    req_d = 1'b0;
                    rty_d = rty_q + 1'b1;
                    if (rty_q + 1'b1 == RW'(MAX_RETRY)) begin
                        state_d   = ERROR;
                        error_d   = 1'b1;
                        busy_d    = 1'b0;
                        err_idx_d = idx_q;
                    end else begin
                        gap_d = 1'b1;
                    end
                end else if (sccb_ack) begin
                    req_d   = 1'b0;
                    state_d = last ? DONE : FETCH;
                    idx_d   = last ? idx_q : idx_q + 1'b1;
                    done_d  = last;
                    busy_d  = !last;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            DELAY: begin
                if (tmr_q == '0) begin
                    state_d = last ? DONE : FETCH;
                    idx_d   = last ? idx_q : idx_q + 1'b1;
                    done_d  = last;
                    busy_d  = !last;
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and registered outputs; arm_q makes the first cycle after reset act as a start pulse
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            tbl_addr_q <= '0;
            err_idx_q  <= '0;
            tmr_q      <= '0;
            rty_q      <= '0;
            reg_q      <= '0;
            wdata_q    <= '0;
            ph_q       <= 1'b0;
            gap_q      <= 1'b0;
            arm_q      <= AUTO_START;
            req_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            tbl_addr_q <= tbl_addr_d;
            err_idx_q  <= err_idx_d;
            tmr_q      <= tmr_d;
            rty_q      <= rty_d;
            reg_q      <= reg_d;
            wdata_q    <= wdata_d;
            ph_q       <= ph_d;
            gap_q      <= gap_d;
            arm_q      <= arm_d;
            req_q      <= req_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            error_q    <= error_d;
        end
    end

endmodule

// File: tb/tb_sccb_config_sequencer.sv
// tb_sccb_config_sequencer: directed scoreboard bench with a table model and a scripted SCCB slave
module tb_sccb_config_sequencer;

    localparam int AW  = 3;
    localparam int DLY = 20;
    localparam int TO  = 100;

    typedef struct {
        logic [15:0] f;
        int          rise;
        int          low;
    } att_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] tbl_addr;
    logic [15:0]   tbl_data = 16'h0;
    logic          sccb_req;
    logic [7:0]    dev, ra, wd;
    logic          ack = 1'b0;
    logic          nack = 1'b0;
    logic          busy, done, error;
    logic [AW-1:0] err_index;

    logic [15:0] tbl [8];
    att_t        obs [$];
    logic [15:0] exp_q [$];
    int          cyc = 0;
    int          compared = 0;
    int          mismatched = 0;
    int          fall_cyc = 0;
    int          unstable = 0;
    logic        prev_req = 1'b0;
    logic [15:0] cur_f = 16'h0;
    logic [AW-1:0] prev_addr = '0;
    bit          watch = 0;
    bit          wrapped = 0;
    int          nack_target = 0;
    int          nacks_given = 0;
    bit          nack_on = 0;
    logic [7:0]  nack_reg = 8'h00;
    bit          silent = 0;
    int          stale_req = 0;
    int          stale_seen = 0;
    int          rc = 0;
    bit          sent = 0;

    sccb_config_sequencer #(
        .DEV_ADDR(8'h42), .TBL_AW(AW), .DELAY_CYC(DLY), .ACK_TIMEOUT(TO),
        .MAX_RETRY(3), .AUTO_START(1'b1)
    ) dut (
        .clk(clk), .reset(rst_n), .start(start), .tbl_addr(tbl_addr), .tbl_data(tbl_data),
        .sccb_req(sccb_req), .sccb_dev_addr(dev), .sccb_reg_addr(ra), .sccb_wdata(wd),
        .sccb_ack(ack), .sccb_nack(nack), .busy(busy), .done(done), .error(error),
        .err_index(err_index)
    );

    always #5 clk = ~clk;

    // Cycle count and 1-cycle-latency table ROM model
    always @(posedge clk) begin
        cyc++;
        tbl_data <= tbl[tbl_addr];
    end

    // Monitor: record each request attempt, field stability and address wrap
    always @(negedge clk) begin
        if (sccb_req && !prev_req) begin
            obs.push_back('{{ra, wd}, cyc, cyc - fall_cyc});
            cur_f = {ra, wd};
        end
        if (sccb_req && prev_req && ({ra, wd} !== cur_f || dev !== 8'h42)) unstable++;
        if (!sccb_req && prev_req) fall_cyc = cyc;
        if (watch && tbl_addr < prev_addr) wrapped = 1;
        prev_addr = tbl_addr;
        prev_req  = sccb_req;
    end

    // Slave: answers on the third cycle of each attempt, or injects a stale ack on request
    always @(negedge clk) begin
        ack  = 1'b0;
        nack = 1'b0;
        if (stale_req != stale_seen) begin
            ack = 1'b1;
            stale_seen = stale_req;
        end else if (sccb_req && !sent) begin
            rc++;
            if (rc == 3 && !silent) begin
                sent = 1;
                if (nacks_given < nack_target || (nack_on && ra == nack_reg)) begin
                    nack = 1'b1;
                    if (nacks_given < nack_target) nacks_given++;
                end else begin
                    ack = 1'b1;
                end
            end
        end
        if (!sccb_req) begin
            rc   = 0;
            sent = 0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        compared++;
        assert (o === e) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, o, e);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic wait_end(input string tag, input int lim);
        int n = 0;
        while (!(!busy && (done || error)) && n < lim) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_in_time"}, 32'(n < lim), 1);
    endtask

    task automatic wait_obs(input string tag, input int cnt, input int lim);
        int n = 0;
        while (obs.size() < cnt && n < lim) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_in_time"}, 32'(n < lim), 1);
    endtask

    task automatic pop_chk(input string tag, output att_t a);
        if (obs.size() == 0 || exp_q.size() == 0) begin
            chk({tag, "_present"}, 32'(obs.size()), 32'(exp_q.size() + 1));
            a = '{16'h0, 0, 0};
        end else begin
            a = obs.pop_front();
            chk({tag, "_fields"}, 32'(a.f), 32'(exp_q.pop_front()));
        end
    endtask

    task automatic fill(input logic [15:0] v);
        for (int i = 0; i < 8; i++) tbl[i] = v;
    endtask

    initial begin
        att_t a, b, c;
        int   c0;
        // Reset state and auto-start run with delay marker
        fill(16'hFFFF);
        tbl[0] = 16'h1280; tbl[1] = 16'hFFF0; tbl[2] = 16'h1101;
        exp_q.push_back(16'h1280); exp_q.push_back(16'h1101);
        step(3);
        chk("rst_req", 32'(sccb_req), 0);
        chk("rst_flags", 32'({busy, done, error}), 0);
        chk("rst_addr", 32'({tbl_addr, err_index}), 0);
        @(negedge clk) rst_n = 1'b1;
        c0 = cyc;
        wait_end("t1", 200);
        pop_chk("t1_w0", a);
        chk("t1_latency", 32'(a.rise), 32'(c0 + 4));
        pop_chk("t1_w1", b);
        chk("t1_delay_gap", 32'(b.rise - a.rise >= DLY), 1);
        chk("t1_flags", 32'({done, busy, error}), 32'(3'b100));
        chk("t1_no_extra", 32'(obs.size()), 0);

        // Two NACKs then ACK: three identical attempts, 1-cycle low between
        fill(16'hFFFF);
        tbl[0] = 16'h3A04;
        repeat (3) exp_q.push_back(16'h3A04);
        nack_target = nacks_given + 2;
        pulse_start();
        wait_end("t2", 200);
        pop_chk("t2_a0", a);
        pop_chk("t2_a1", b);
        chk("t2_low1", 32'(b.low), 1);
        pop_chk("t2_a2", c);
        chk("t2_low2", 32'(c.low), 1);
        chk("t2_flags", 32'({done, error}), 32'(2'b10));
        chk("t2_no_extra", 32'(obs.size()), 0);

        // Persistent NACK at index 5 -> error; restart clears it
        fill(16'hFFFF);
        for (int i = 0; i < 5; i++) tbl[i] = {8'(i + 1), 8'(i + 1)};
        tbl[5] = 16'h5555;
        nack_on = 1; nack_reg = 8'h55;
        for (int i = 0; i < 5; i++) exp_q.push_back(tbl[i]);
        repeat (3) exp_q.push_back(16'h5555);
        pulse_start();
        wait_end("t3", 400);
        for (int i = 0; i < 8; i++) pop_chk("t3_w", a);
        chk("t3_flags", 32'({error, busy, done}), 32'(3'b100));
        chk("t3_err_index", 32'(err_index), 5);
        step(30);
        chk("t3_no_more_req", 32'(obs.size()), 0);
        nack_on = 0;
        for (int i = 0; i < 6; i++) exp_q.push_back(tbl[i]);
        pulse_start();
        chk("t3_restart", 32'({error, busy}), 32'(2'b01));
        wait_end("t3b", 400);
        for (int i = 0; i < 6; i++) pop_chk("t3b_w", a);
        chk("t3b_flags", 32'({done, error}), 32'(2'b10));

        // Silent slave: timeout after ACK_TIMEOUT+1 high cycles, three attempts
        fill(16'hFFFF);
        tbl[0] = 16'h2233;
        repeat (3) exp_q.push_back(16'h2233);
        silent = 1;
        pulse_start();
        wait_end("t4", 600);
        pop_chk("t4_a0", a);
        pop_chk("t4_a1", b);
        pop_chk("t4_a2", c);
        chk("t4_period1", 32'(b.rise - a.rise), 32'(TO + 2));
        chk("t4_period2", 32'(c.rise - b.rise), 32'(TO + 2));
        chk("t4_flags", 32'({error, err_index}), 32'({1'b1, 3'd0}));
        chk("t4_no_extra", 32'(obs.size()), 0);

        // Reset mid-REQ, fresh auto-run, stale acks ignored
        fill(16'hFFFF);
        tbl[0] = 16'h4455; tbl[1] = 16'hFFF0; tbl[2] = 16'h6677;
        pulse_start();
        wait_obs("t5_req", 1, 20);
        step(5);
        #2 rst_n = 1'b0;
        #1 chk("t5_async_req", 32'(sccb_req), 0);
        chk("t5_async_busy", 32'(busy), 0);
        silent = 0;
        step(2);
        obs.delete();
        exp_q.push_back(16'h4455); exp_q.push_back(16'h6677);
        rst_n = 1'b1;
        c0 = cyc;
        wait_obs("t5_first", 1, 20);
        while (sccb_req) @(negedge clk);
        step(5);
        stale_req++;
        wait_end("t5", 200);
        pop_chk("t5_w0", a);
        chk("t5_fresh_latency", 32'(a.rise), 32'(c0 + 4));
        pop_chk("t5_w1", b);
        chk("t5_delay_kept", 32'(b.rise - a.rise >= DLY), 1);
        stale_req++;
        step(4);
        chk("t5_stale_idle", 32'({done, busy, error}), 32'(3'b100));
        chk("t5_no_extra", 32'(obs.size()), 0);

        // No end marker: eight writes, no wrap, start during run ignored
        for (int i = 0; i < 8; i++) begin
            tbl[i] = {8'(8'h20 + i), 8'(8'hA0 + i)};
            exp_q.push_back(tbl[i]);
        end
        pulse_start();
        wait_obs("t6_first", 1, 20);
        watch = 1;
        wait_obs("t6_third", 3, 60);
        pulse_start();
        wait_end("t6", 400);
        step(20);
        watch = 0;
        for (int i = 0; i < 8; i++) pop_chk("t6_w", a);
        chk("t6_flags", 32'({done, busy, error}), 32'(3'b100));
        chk("t6_no_wrap", 32'(wrapped), 0);
        chk("t6_no_extra", 32'(obs.size()), 0);
        chk("fields_stable", 32'(unstable), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/sccb_config_sequencer.md
Name: sccb_config_sequencer

Overview:
Walks a camera register-init table and issues one SCCB write per entry to the existing SCCB write engine through a req/ack handshake. Supports an inline delay marker, used after the COM7 soft reset, and a bounded retry on NACK or timeout. Reports busy/done/error to the top level. Runs automatically after reset and re-runs on a start pulse, e.g. to reload the camera when switching upscale mode.

Parameters:
DEV_ADDR, 8'h42, SCCB write device address driven on every request
TBL_AW, 7, table address width; table depth is 2**TBL_AW
DELAY_CYC, 1_000_000, wait length for a delay marker (10 ms at 100 MHz)
ACK_TIMEOUT, 65_535, cycles waited for ack/nack before treating the write as a NACK
MAX_RETRY, 3, write attempts per entry before error
AUTO_START, 1, when 1, start a run on the first cycle after reset release

Ports:
clk  in  1  system clock (100 MHz)
reset  in  1  asynchronous, active-low reset
start  in  1  single-cycle pulse; begins a run from index 0 (debounced upstream)
tbl_addr  out  TBL_AW  table read address
tbl_data  in  16  table entry {reg_addr[15:8], value[7:0]}; synchronous ROM, 1-cycle read latency
sccb_req  out  1  write request to the SCCB engine
sccb_dev_addr  out  8  equals DEV_ADDR
sccb_reg_addr  out  8  register address
sccb_wdata  out  8  register value
sccb_ack  in  1  1-cycle pulse: write completed, slave ACKed
sccb_nack  in  1  1-cycle pulse: write completed, slave NACKed
busy  out  1  run in progress
done  out  1  last run completed cleanly (sticky until the next run starts)
error  out  1  last run aborted (sticky until the next run starts)
err_index  out  TBL_AW  table index that failed

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; all outputs 0; index, retry_cnt and timers cleared.
- Table entry codes:
  - 16'hFFFF = end of table.
  - 16'hFFF0 = delay marker.
  - Any other value = normal write.
- States: IDLE, FETCH, DECODE, REQ, DELAY, DONE, ERROR.
- IDLE/DONE/ERROR:
  - start=1 -> FETCH with index=0, done=0, error=0, busy=1.
  - If AUTO_START=1, the first cycle after reset release behaves as start=1.
- FETCH: tbl_addr=index. Next cycle -> DECODE.
- DECODE: tbl_data is valid.
  - FFFF -> DONE (done=1, busy=0).
  - FFF0 -> DELAY with the timer loaded to DELAY_CYC-1.
  - Otherwise latch reg_addr/wdata, set retry_cnt=0, assert sccb_req, go to REQ.
  - Timing: start sampled at edge N gives sccb_req=1 after edge N+3.
- REQ: sccb_req stays high and the address/data fields stay stable until sccb_ack or sccb_nack is seen.
  - sccb_req drops in the cycle after the response.
  - The timeout counter runs while in REQ; reaching ACK_TIMEOUT counts as a NACK.
  - ack -> advance to the next entry (see below).
  - nack/timeout -> retry_cnt+1:
    - If the new retry_cnt == MAX_RETRY -> ERROR (error=1, busy=0, err_index=index).
    - Otherwise drop req for exactly 1 cycle, then re-assert it with the same fields.
  - If ack and nack arrive in the same cycle, nack wins.
- DELAY: the timer counts down to 0, then advance to the next entry. No SCCB activity during the delay.
- Advance: if index == 2**TBL_AW-1, go to DONE with no wrap-around. Otherwise index+1 -> FETCH.
- start while busy=1 is ignored.
- The engine is never left with a dangling request: after reset, sccb_req=0 immediately. A response arriving outside REQ is ignored.
- Widths: timers are sized with $clog2(max(DELAY_CYC, ACK_TIMEOUT)+1). retry_cnt is $clog2(MAX_RETRY+1) bits.

Decomposition:
- Package cam_cfg_pkg holds:
  - the state enum;
  - TBL_END=16'hFFFF and TBL_DELAY=16'hFFF0;
  - OV7670 register-address constants such as COM7=8'h12.
- The table ROM is a separate sub-module, ov7670_cfg_rom (addr in, data out, registered), instantiated beside this block at the top level. It is not inside this block, so the bench can substitute its own table.

Test Plan:
1. Table {12_80, FFF0, 11_01, FFFF}, auto-start, slave always ACKs -> two writes, (12,80) then (11,01). Gap between them ≥ DELAY_CYC cycles. done=1, busy=0, error=0.
2. Slave NACKs (3A,04) twice then ACKs -> exactly 3 req assertions with identical fields, each separated by a 1-cycle low. Run finishes with done=1.
3. Slave always NACKs at index 5 with MAX_RETRY=3 -> 3 attempts, then error=1, err_index=5, busy=0, and no further reqs. A later start pulse clears error and restarts from index 0.
4. Slave never responds, ACK_TIMEOUT=100 -> req drops 101 cycles after rising and is retried. After 3 attempts error=1.
5. Reset asserted mid-REQ -> sccb_req=0 asynchronously. After release, a fresh run starts at index 0. A stale ack pulse arriving while not in REQ is ignored.
6. Table with no FFFF, TBL_AW=3 -> 8 writes (indices 0..7), then done=1. tbl_addr never wraps to 0. A start pulse during the run has no effect.
